// File: rtl/arb4_pkg.sv
// Shared types and sizes for the 4-way round-robin arbiter.
package arb4_pkg;

   localparam int NUM_REQ = 4;
   localparam int SEL_W   = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      OWNED = 1'b1
   } arb_state_t;

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: the first eligible request after base wins,
// with base itself searched last.
module rr_pick4
   import arb4_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [SEL_W-1:0]   base,
   input  logic [NUM_REQ-1:0] excl,
   output logic               any,
   output logic [SEL_W-1:0]   idx,
   output logic [NUM_REQ-1:0] onehot
);

   logic [NUM_REQ-1:0] cand;
   logic [SEL_W-1:0]   pos;

   assign cand = req & ~excl;

   // NOTE: every output of a combinational block gets a default before any
   // conditional assignment, otherwise synthesis infers a latch.
   always_comb begin
      any    = |cand;
      idx    = '0;
      onehot = '0;
      pos    = '0;
      // Walk from the farthest slot toward base+1 so the nearest hit overrides.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         pos = base + SEL_W'(k + 1);
         if (cand[pos]) idx = pos;
      end
      if (any) onehot[idx] = 1'b1;
   end

endmodule

// File: rtl/arb4way_ctrl.sv
// Round-robin arbiter driving the select of the shared DMUX4Way; the owner keeps
// the grant until release, or until MAX_HOLD cycles expire while others wait.
module arb4way_ctrl
   import arb4_pkg::*;
#(
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic [SEL_W-1:0]   s,
   output logic               busy,
   output logic               preempt
);

   localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

   arb_state_t         state, nxt_state;
   logic [SEL_W-1:0]   owner, nxt_owner;
   logic [SEL_W-1:0]   last, nxt_last;
   logic [CNT_W-1:0]   hold_cnt, nxt_hold_cnt;
   logic [NUM_REQ-1:0] nxt_gnt;
   logic [SEL_W-1:0]   nxt_s;
   logic               nxt_busy, nxt_preempt;

   logic               take, expire;
   logic [NUM_REQ-1:0] excl;
   logic               pick_any;
   logic [SEL_W-1:0]   pick_idx;
   logic [NUM_REQ-1:0] pick_onehot;

   // The current owner never competes against itself; when it has released,
   // its req bit is already low so the mask changes nothing.
   always_comb begin
      excl = '0;
      if (state == OWNED) excl[owner] = 1'b1;
   end

   rr_pick4 u_pick (
      .req    (req),
      .base   (last),
      .excl   (excl),
      .any    (pick_any),
      .idx    (pick_idx),
      .onehot (pick_onehot)
   );

   // NOTE: all state uses non-blocking assignments so every register samples
   // the pre-edge values, whatever the statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         owner    <= '0;
         last     <= SEL_W'(NUM_REQ - 1);
         hold_cnt <= '0;
         gnt      <= '0;
         s        <= '0;
         busy     <= 1'b0;
         preempt  <= 1'b0;
      end else begin
         state    <= nxt_state;
         owner    <= nxt_owner;
         last     <= nxt_last;
         hold_cnt <= nxt_hold_cnt;
         gnt      <= nxt_gnt;
         s        <= nxt_s;
         busy     <= nxt_busy;
         preempt  <= nxt_preempt;
      end
   end

   always_comb begin
      nxt_state = state;
      take      = 1'b0;
      expire    = 1'b0;
      unique case (state)
         IDLE: begin
            if (pick_any) begin
               nxt_state = OWNED;
               take      = 1'b1;
            end
         end
         OWNED: begin
            if (!req[owner]) begin
               if (pick_any) take      = 1'b1;
               else          nxt_state = IDLE;
            end else if (hold_cnt == HOLD_MAX && pick_any) begin
               take   = 1'b1;
               expire = 1'b1;
            end
         end
         default: nxt_state = IDLE;
      endcase
   end

   always_comb begin
      nxt_owner    = owner;
      nxt_last     = last;
      nxt_gnt      = gnt;
      nxt_s        = s;
      nxt_busy     = busy;
      nxt_preempt  = expire;
      nxt_hold_cnt = hold_cnt;
      if (take) begin
         nxt_owner    = pick_idx;
         nxt_last     = pick_idx;
         nxt_gnt      = pick_onehot;
         nxt_s        = pick_idx;
         nxt_busy     = 1'b1;
         nxt_hold_cnt = CNT_W'(1);
      end else if (nxt_state == IDLE) begin
         // s keeps the last owner so the demux select does not glitch.
         nxt_gnt      = '0;
         nxt_busy     = 1'b0;
         nxt_hold_cnt = '0;
      end else if (hold_cnt != HOLD_MAX) begin
         nxt_hold_cnt = hold_cnt + 1'b1;
      end
   end

endmodule

// File: doc/arb4way_ctrl.md
# arb4way_ctrl

Round-robin arbiter and sequencer for the shared 4-way demultiplexer path. Four requesters compete for one shared data source. The block grants exactly one requester at a time, drives the 2-bit `s` select of the downstream DMUX4Way, and holds the grant until the owner releases it or its hold budget expires while others wait. It sits between the requesters' control logic and the `s` input of the demux. The demux's `X` input carries the shared data unchanged.

## Interface
Parameters:
- `MAX_HOLD`, default 8: maximum consecutive cycles one owner keeps the grant while another request is pending. Legal range is 2..255.
- `CNT_W`, default 8: width of the hold counter. Must satisfy `2**CNT_W > MAX_HOLD`.

Ports:
- `clk`: input, 1 bit. Single clock; all state updates on its rising edge.
- `reset`: input, 1 bit. Synchronous, active-high.
- `req`: input, 4 bits. `req[i]` high means requester i wants, or keeps, the resource. Bit 0 corresponds to `OUT1`, bit 3 to `OUT4`.
- `gnt`: output, 4 bits. Registered, one-hot or zero; the current owner.
- `s`: output, 2 bits. Registered; the demux select, equal to the owner index.
- `busy`: output, 1 bit. Registered; high while any grant is active.
- `preempt`: output, 1 bit. Registered; one-cycle pulse when an owner loses the grant due to hold expiry.

## Operation
State machine with two states, IDLE and OWNED. Internal registers:
- `owner[1:0]`
- `last[1:0]`, the most recent owner
- `hold_cnt[CNT_W-1:0]`

Reset values:
- `gnt` = 4'b0000, `s` = 2'b00, `busy` = 0, `preempt` = 0.
- state = IDLE, `last` = 2'd3 (so requester 0 has top priority first), `hold_cnt` = 0.

Priority rule:
- Search order is `last+1`, `last+2`, `last+3`, `last` (mod 4). The first index with `req` high wins.
- When searching away from a preempted owner, that owner's own `req` is excluded.

IDLE:
- If any `req` is high, grant the winner: `gnt` one-hot, `s` = winner, `busy` = 1, `hold_cnt` = 1, `last` = winner. Go to OWNED.

OWNED, owner releases (`req[owner]` = 0):
- If another `req` is high, switch to its winner in the same edge, with `hold_cnt` = 1.
- Otherwise go to IDLE: `gnt` = 0, `busy` = 0, `s` holds its last value.

OWNED, owner keeps `req` high:
- If `hold_cnt` == `MAX_HOLD` and another `req` is high: preempt. Grant the winner among the others, set `preempt` = 1 for that cycle, `hold_cnt` = 1.
- Otherwise `hold_cnt` increments, saturating at `MAX_HOLD`. A sole requester is never preempted.

General rules:
- `gnt` is never multi-hot.
- `s` always equals the index of the set `gnt` bit whenever `busy` = 1.

## Timing
- Grant latency: `req` sampled high at edge N gives `gnt`/`s`/`busy` valid after edge N, i.e. 1 cycle.
- Handover on release or preemption: 0 idle cycles. The new owner's `gnt` rises on the same edge the old owner's `gnt` falls.
- Maximum wait for a requester held continuously high: 3 × `MAX_HOLD` cycles plus 1.
- `preempt` is high for exactly the one cycle following the preempting edge.
- Simultaneous requests from IDLE resolve by the rotation from `last`, with no bias to index 0 after the first grant.
- Reset asserted mid-grant: on that edge, all outputs and registers return to their reset values. A `req` present while reset is high is ignored. Arbitration starts on the first edge with `reset` low.
- A `req` that drops and rises within one cycle between edges is not seen.

## Structure
- Package `arb4_pkg` contains:
  - typedef enum `arb_state_t` {IDLE, OWNED}
  - localparam `NUM_REQ` = 4
  - localparam `SEL_W` = 2
- Sub-module `rr_pick4`: purely combinational. Inputs are `req[3:0]`, `base[1:0]` and `excl` (a 4-bit mask). Outputs are `any`, `idx[1:0]` and `onehot[3:0]`. It is instantiated once in `arb4way_ctrl`.
- The top level contains the FSM, the hold counter and the output registers.
- The integration bench instantiates `arb4way_ctrl` driving `s` of DMUX4Way with `X` = 1, and checks that `OUT(i+1)` == `gnt[i]` while `busy` is high.

## Test plan
1. **Reset:** hold `reset` for 2 cycles with `req` = 4'b1111. Required: `gnt` = 0, `s` = 0, `busy` = 0 throughout. First edge after release gives `gnt` = 4'b0001, `s` = 0.
2. **Rotation:** with `MAX_HOLD` = 8, `req` = 4'b1111, and each owner dropping its `req` for one cycle after 3 cycles of ownership. Required grant order is 0, 1, 2, 3, 0 with no cycle where `gnt` = 0.
3. **Preemption:** with `MAX_HOLD` = 4, `req[2]` held high from idle, then `req[0]` raised at cycle 2 of ownership. Required: `gnt` = 4'b0100 for exactly 4 cycles, then 4'b0001 with a single `preempt` pulse.
4. **Sole owner:** `req` = 4'b1000 held for 20 cycles. Required: `gnt` = 4'b1000 and `s` = 3 for all 20 cycles, `preempt` never high, and `hold_cnt` saturates at `MAX_HOLD`.
5. **Release to idle:** grant requester 1, then `req` = 0. Required on the next edge: `gnt` = 0, `busy` = 0, `s` stays 1. A later `req` = 4'b0011 grants 2'd0 first, since rotation starts after `last` = 1 and index 1 is searched last.
6. **Reset mid-grant:** `reset` pulses for 1 cycle while `gnt` = 4'b0100 with `req` = 4'b0110. Required: all outputs at reset values for that cycle, and the next grant is to requester 1 (rotation from `last` = 3 reaches index 1 before index 2).
